// File: rtl/pcpi_fp_dispatch_if.sv
// Bundle of the PCPI core bus and the adder request/response channels.
// master: dispatcher side; slave: core + adder side.
interface pcpi_fp_dispatch_if;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic [31:0] pcpi_rs1;
   logic [31:0] pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;
   logic        u_req_valid;
   logic        u_req_ready;
   logic [31:0] u_a;
   logic [31:0] u_b;
   logic        u_rsp_valid;
   logic [31:0] u_rsp_z;
   logic        u_rsp_ready;

   modport master (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
             u_req_ready, u_rsp_valid, u_rsp_z,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
             u_req_valid, u_a, u_b, u_rsp_ready
   );

   modport slave (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
             u_req_ready, u_rsp_valid, u_rsp_z,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
             u_req_valid, u_a, u_b, u_rsp_ready
   );
endinterface

// File: rtl/pcpi_fp_dispatch.sv
// PCPI front end for the FP add unit: decodes custom-0 FADD/FSUB, issues the
// operands to the adder, returns its result, and guards against a hung unit.
module pcpi_fp_dispatch #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [6:0]  FSUB_FUNCT7    = 7'b0000100
) (
   input  logic                clk,
   input  logic                reset,
   pcpi_fp_dispatch_if.master  bus,
   output logic                err_timeout,
   output logic                err_stale
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;
   localparam logic [2:0] S_DISCARD = 3'd5;

   localparam logic [15:0] EXPIRE   = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;

   logic [2:0]  state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] z_q, z_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_timeout_q, err_timeout_d;
   logic        err_stale_q, err_stale_d;

   logic insn_ok, is_fadd, is_fsub, hit, expired, req_fire, rsp_fire;
   logic unused_insn_bits;

   assign insn_ok = bus.pcpi_valid && (bus.pcpi_insn[6:0] == 7'b0001011)
                    && (bus.pcpi_insn[14:12] == 3'b000);
   assign is_fadd = (bus.pcpi_insn[31:25] == 7'b0000000);
   assign is_fsub = (bus.pcpi_insn[31:25] == FSUB_FUNCT7);
   assign hit     = insn_ok && (is_fadd || is_fsub);
   assign unused_insn_bits = ^{bus.pcpi_insn[24:15], bus.pcpi_insn[11:7]};

   // A handshake accepted on the expiry cycle parks the count past EXPIRE,
   // so the compare is >= to still bound the following state.
   assign expired = (cnt_q >= EXPIRE);

   assign bus.u_req_valid = (state_q == S_ISSUE);
   assign bus.u_rsp_ready = (state_q != S_ISSUE);
   assign bus.u_a         = a_q;
   assign bus.u_b         = b_q;
   assign bus.pcpi_wait   = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign bus.pcpi_ready  = (state_q == S_DONE);
   assign bus.pcpi_wr     = (state_q == S_DONE);
   assign bus.pcpi_rd     = z_q;
   assign err_timeout     = err_timeout_q;
   assign err_stale       = err_stale_q;

   assign req_fire = bus.u_req_valid && bus.u_req_ready;
   assign rsp_fire = bus.u_rsp_ready && bus.u_rsp_valid;

   always_comb begin
      // NOTE: every target gets its hold value first, so no path can infer a latch.
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      z_d           = z_q;
      cnt_d         = cnt_q;
      err_timeout_d = err_timeout_q;
      err_stale_d   = err_stale_q;

      if ((state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DISCARD))
         cnt_d = cnt_q + 16'd1;

      case (state_q)
         S_IDLE: begin
            if (rsp_fire) err_stale_d = 1'b1;
            if (hit) begin
               a_d     = bus.pcpi_rs1;
               b_d     = is_fsub ? {~bus.pcpi_rs2[31], bus.pcpi_rs2[30:0]} : bus.pcpi_rs2;
               cnt_d   = 16'd0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (req_fire) state_d = S_WAIT;
            else if (!bus.pcpi_valid) state_d = S_IDLE;
            else if (expired) begin
               z_d           = QNAN;
               err_timeout_d = 1'b1;
               state_d       = S_DONE;
            end
         end
         S_WAIT: begin
            // A response that lands on the abort cycle is the one DISCARD would
            // wait for, so it is dropped here directly.
            if (rsp_fire) begin
               if (bus.pcpi_valid) begin
                  z_d     = bus.u_rsp_z;
                  state_d = S_DONE;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (!bus.pcpi_valid) state_d = S_DISCARD;
            else if (expired) begin
               z_d           = QNAN;
               err_timeout_d = 1'b1;
               state_d       = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_fire) err_stale_d = 1'b1;
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (rsp_fire) err_stale_d = 1'b1;
            if (!bus.pcpi_valid) state_d = S_IDLE;
         end
         S_DISCARD: begin
            if (rsp_fire) state_d = S_IDLE;
            else if (expired) begin
               err_timeout_d = 1'b1;
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         a_q           <= '0;
         b_q           <= '0;
         z_q           <= '0;
         cnt_q         <= '0;
         err_timeout_q <= 1'b0;
         err_stale_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         z_q           <= z_d;
         cnt_q         <= cnt_d;
         err_timeout_q <= err_timeout_d;
         err_stale_q   <= err_stale_d;
      end
   end

endmodule

// File: tb/tb_pcpi_fp_dispatch.sv
// Randomized bench for pcpi_fp_dispatch: a transaction-level model predicts the
// completion cycle, result and flags from the unit's handshake delays.
module tb_pcpi_fp_dispatch;
   localparam int          T     = 64;
   localparam logic [6:0]  FSUB7 = 7'b0000100;
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   logic clk = 1'b0;
   logic reset;
   logic err_timeout, err_stale;
   pcpi_fp_dispatch_if bus();

   int   n_checks = 0;
   int   n_bad    = 0;
   logic exp_to    = 1'b0;
   logic exp_stale = 1'b0;

   always #5 clk = ~clk;

   pcpi_fp_dispatch #(.TIMEOUT_CYCLES(T), .FSUB_FUNCT7(FSUB7)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.master),
      .err_timeout (err_timeout),
      .err_stale   (err_stale)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Stand-in adder: exact sums for the directed operand pairs, a scramble otherwise.
   function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         64'h3F800000_40000000: return 32'h4040_0000;
         64'h40400000_BF800000: return 32'h4000_0000;
         64'h3F800000_3F800000: return 32'h4000_0000;
         default:               return (a ^ {b[15:0], b[31:16]}) + 32'h1357;
      endcase
   endfunction

   function automatic logic [31:0] make_insn(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
   endfunction

   task automatic drive_idle();
      bus.pcpi_valid  = 1'b0;
      bus.pcpi_insn   = '0;
      bus.pcpi_rs1    = '0;
      bus.pcpi_rs2    = '0;
      bus.u_req_ready = 1'b0;
      bus.u_rsp_valid = 1'b0;
      bus.u_rsp_z     = '0;
   endtask

   // One instruction: the unit accepts the request d1 cycles into ISSUE and
   // answers d2 cycles after that; abort_at >= 0 drops pcpi_valid from that cycle.
   task automatic run_txn(input string tag, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [6:0] f7, input logic [2:0] f3,
                          input int d1, input int d2, input int linger, input int abort_at);
      int h_exp, r_exp, wdl, exp_ready, exp_hs, n_cyc;
      int got_ready = -1, hs_cyc = -1, hs_cnt = 0, rdy_cnt = 0, wr_cnt = 0, wait_bad = 0;
      logic [31:0] exp_a, exp_b, exp_rd, got_rd, unit_a, unit_b;
      bit claimed, hang_req, hang_rsp, exp_wait;
      got_rd = '0; unit_a = '0; unit_b = '0;
      claimed = (f3 == 3'b000) && ((f7 == 7'd0) || (f7 == FSUB7));
      exp_a   = rs1;
      exp_b   = (f7 == FSUB7) ? {~rs2[31], rs2[30:0]} : rs2;
      exp_rd  = unit_fn(exp_a, exp_b);
      h_exp   = 1 + d1;
      r_exp   = h_exp + 1 + d2;
      wdl     = (T > h_exp + 1) ? T : h_exp + 1;
      hang_req = (h_exp > T);
      hang_rsp = (r_exp > wdl);
      if (!claimed) begin
         exp_ready = -1; exp_hs = 0;
      end else if (abort_at >= 0) begin
         exp_ready = -1; exp_hs = (abort_at >= h_exp) ? 1 : 0;
      end else if (hang_req) begin
         exp_ready = T + 1; exp_rd = QNAN; exp_hs = 0; exp_to = 1'b1;
      end else if (hang_rsp) begin
         exp_ready = wdl + 1; exp_rd = QNAN; exp_hs = 1; exp_to = 1'b1;
      end else begin
         exp_ready = r_exp + 1; exp_hs = 1;
      end
      n_cyc = (exp_ready >= 0) ? exp_ready + linger + 3 : ((abort_at >= 0) ? r_exp + 4 : 20);

      for (int cyc = 0; cyc <= n_cyc; cyc++) begin
         @(negedge clk);
         bus.pcpi_valid  = ((abort_at < 0) || (cyc < abort_at))
                           && ((got_ready < 0) || (cyc <= got_ready + linger));
         bus.pcpi_insn   = make_insn(f7, f3);
         bus.pcpi_rs1    = rs1;
         bus.pcpi_rs2    = rs2;
         bus.u_req_ready = claimed && !hang_req && (cyc == h_exp);
         bus.u_rsp_valid = !hang_rsp && (hs_cyc >= 0) && (cyc == hs_cyc + 1 + d2);
         bus.u_rsp_z     = unit_fn(unit_a, unit_b);
         #1;
         if (bus.u_req_valid && bus.u_req_ready) begin
            hs_cnt++;
            hs_cyc = cyc;
            unit_a = bus.u_a;
            unit_b = bus.u_b;
            check({tag, "_u_a"}, bus.u_a, exp_a);
            check({tag, "_u_b"}, bus.u_b, exp_b);
         end
         if (bus.pcpi_ready) begin
            rdy_cnt++;
            if (got_ready < 0) begin
               got_ready = cyc;
               got_rd    = bus.pcpi_rd;
            end
         end
         if (bus.pcpi_wr) wr_cnt++;
         exp_wait = claimed && (cyc >= 1)
                    && ((abort_at >= 0) ? (cyc <= abort_at) : (cyc < exp_ready));
         if (bus.pcpi_wait !== exp_wait) wait_bad++;
      end
      drive_idle();

      check({tag, "_ready_cycle"}, got_ready, exp_ready);
      if (exp_ready >= 0) check({tag, "_rd"}, got_rd, exp_rd);
      check({tag, "_ready_pulses"}, rdy_cnt, (exp_ready >= 0) ? 1 : 0);
      check({tag, "_wr_pulses"}, wr_cnt, (exp_ready >= 0) ? 1 : 0);
      check({tag, "_req_handshakes"}, hs_cnt, exp_hs);
      check({tag, "_wait_bad_cycles"}, wait_bad, 0);
      check({tag, "_err_timeout"}, {31'd0, err_timeout}, {31'd0, exp_to});
      check({tag, "_err_stale"}, {31'd0, err_stale}, {31'd0, exp_stale});
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_wait"},  {31'd0, bus.pcpi_wait},   32'd0);
      check({tag, "_ready"}, {31'd0, bus.pcpi_ready},  32'd0);
      check({tag, "_wr"},    {31'd0, bus.pcpi_wr},     32'd0);
      check({tag, "_rd"},    bus.pcpi_rd,              32'd0);
      check({tag, "_req"},   {31'd0, bus.u_req_valid}, 32'd0);
      check({tag, "_u_a"},   bus.u_a,                  32'd0);
      check({tag, "_u_b"},   bus.u_b,                  32'd0);
      check({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
      check({tag, "_err_stale"},   {31'd0, err_stale},   32'd0);
   endtask

   initial begin
      int d1, d2;
      logic [6:0] f7;
      logic [2:0] f3;
      drive_idle();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_outputs_zero("reset");

      run_txn("fadd", 32'h3F80_0000, 32'h4000_0000, 7'd0,  3'd0, 0, 0, 0, -1);
      run_txn("fsub", 32'h4040_0000, 32'h3F80_0000, FSUB7, 3'd0, 0, 0, 0, -1);
      run_txn("bad_funct7", 32'h3F80_0000, 32'h4000_0000, 7'd1, 3'd0, 0, 0, 0, -1);
      run_txn("bad_funct3", 32'h3F80_0000, 32'h4000_0000, 7'd0, 3'd1, 0, 0, 0, -1);
      run_txn("drain", 32'h3F80_0000, 32'h4000_0000, 7'd0, 3'd0, 1, 2, 3, -1);
      run_txn("abort_issue", 32'h1234_5678, 32'h0BAD_F00D, 7'd0, 3'd0, 5, 0, 0, 2);
      run_txn("abort_wait",  32'h1234_5678, 32'h0BAD_F00D, 7'd0, 3'd0, 0, 2, 0, 3);
      run_txn("timeout", 32'h3F80_0000, 32'h4000_0000, 7'd0, 3'd0, 0, 200, 0, -1);

      @(negedge clk);
      bus.u_rsp_valid = 1'b1;
      bus.u_rsp_z     = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.u_rsp_valid = 1'b0;
      #1;
      exp_stale = 1'b1;
      check("late_rsp_err_stale", {31'd0, err_stale}, 32'd1);
      run_txn("after_timeout", 32'h3F80_0000, 32'h3F80_0000, 7'd0, 3'd0, 0, 0, 0, -1);

      // Reset while WAIT_RSP is outstanding.
      @(negedge clk);
      bus.pcpi_valid = 1'b1;
      bus.pcpi_insn  = make_insn(7'd0, 3'd0);
      bus.pcpi_rs1   = 32'h3F80_0000;
      bus.pcpi_rs2   = 32'h4000_0000;
      @(negedge clk);
      bus.u_req_ready = 1'b1;
      @(negedge clk);
      bus.u_req_ready = 1'b0;
      #1;
      check("pre_reset_wait", {31'd0, bus.pcpi_wait}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.pcpi_valid = 1'b0;
      #1;
      exp_to = 1'b0;
      exp_stale = 1'b0;
      check_outputs_zero("reset_wait");
      bus.u_rsp_valid = 1'b1;
      bus.u_rsp_z     = 32'h4040_0000;
      @(negedge clk);
      bus.u_rsp_valid = 1'b0;
      #1;
      exp_stale = 1'b1;
      check("post_reset_err_stale",   {31'd0, err_stale},      32'd1);
      check("post_reset_err_timeout", {31'd0, err_timeout},    32'd0);
      check("post_reset_ready",       {31'd0, bus.pcpi_ready}, 32'd0);
      check("post_reset_rd",          bus.pcpi_rd,             32'd0);

      for (int i = 0; i < 30; i++) begin
         d1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 70)) : int'($urandom_range(0, 4));
         d2 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 70)) : int'($urandom_range(0, 6));
         f7 = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ($urandom_range(0, 1) != 0 ? FSUB7 : 7'd0);
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         run_txn($sformatf("rnd%0d", i), $urandom, $urandom, f7, f3, d1, d2,
                 int'($urandom_range(0, 3)), -1);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
